// File: rtl/alu_exec_stage.sv
// Two-stage pipelined MIPS execute unit: stage 1 latches operands and forms the
// AND/OR/SUM/LESS candidates, stage 2 selects and registers result, zero, overflow, illegal.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       alu_ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;

  typedef enum logic [1:0] {
    SEL_AND  = 2'b00,
    SEL_OR   = 2'b01,
    SEL_SUM  = 2'b10,
    SEL_LESS = 2'b11
  } sel_t;

  logic             v1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [3:0]       ctl1;

  logic             sub;
  logic             legal;
  logic             addsub;
  sel_t             sel;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] less;
  logic [WIDTH-1:0] mux;
  logic             ovf;

  logic             s2_free;
  logic             adv;
  logic             accept;

  // Decode the latched ALU control into select, subtract and legality.
  always_comb begin
    sub    = 1'b0;
    legal  = 1'b1;
    addsub = 1'b0;
    sel    = SEL_AND;
    case (ctl1)
      CTL_AND: sel = SEL_AND;
      CTL_OR:  sel = SEL_OR;
      CTL_ADD: begin
        sel    = SEL_SUM;
        addsub = 1'b1;
      end
      CTL_SUB: begin
        sel    = SEL_SUM;
        sub    = 1'b1;
        addsub = 1'b1;
      end
      CTL_SLT: begin
        sel = SEL_LESS;
        sub = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign and_r = a1 & b1;
  assign or_r  = a1 | b1;
  assign b_eff = sub ? ~b1 : b1;
  assign sum   = a1 + b_eff + WIDTH'(sub);
  assign ovf   = (a1[MSB] == b_eff[MSB]) && (sum[MSB] != a1[MSB]);
  // Sign of the true difference, corrected for overflow.
  assign less  = {{(WIDTH-1){1'b0}}, sum[MSB] ^ ovf};

  always_comb begin
    mux = '0;
    case (sel)
      SEL_AND:  mux = and_r;
      SEL_OR:   mux = or_r;
      SEL_SUM:  mux = sum;
      SEL_LESS: mux = less;
      default:  mux = '0;
    endcase
    if (!legal) mux = '0;
  end

  assign s2_free  = !out_valid || out_ready;
  assign adv      = v1 && s2_free;
  assign in_ready = !v1 || s2_free;
  assign accept   = in_valid && in_ready;

  // Stage 1: operand capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      ctl1 <= '0;
    end else begin
      if (accept) begin
        a1   <= op_a;
        b1   <= op_b;
        ctl1 <= alu_ctl;
      end
      v1 <= accept || (v1 && !adv);
    end
  end

  // Stage 2: selected result held for MEM until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (adv) begin
        result   <= mux;
        zero     <= (mux == '0);
        overflow <= legal && addsub && ovf;
        illegal  <= !legal;
      end
      out_valid <= adv || (out_valid && !out_ready);
    end
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Two-stage pipelined MIPS execute unit feeding the ALU result select. Stage 1 computes the four candidate results (AND, OR, SUM, LESS) from registered operands and a decoded 4-bit ALU control. Stage 2 performs the 2-bit select, derives zero and overflow, and holds the result for the MEM stage. Valid/ready handshakes on both sides absorb downstream stalls without losing or duplicating operations.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  stage accepts the operation this cycle
- op_a  input  WIDTH  operand A (rs)
- op_b  input  WIDTH  operand B (rt or sign-extended immediate)
- alu_ctl  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT; all other codes illegal
- out_valid  output  1  result presented to MEM
- out_ready  input  1  MEM consumes result this cycle
- result  output  WIDTH  selected result
- zero  output  1  result == 0
- overflow  output  1  signed overflow (ADD/SUB only)
- illegal  output  1  accepted alu_ctl was an illegal code

## Operation
- Handshake: transfer on valid && ready, on either side.
- Stage 1 (v1): on accept, latch op_a, op_b, alu_ctl.
  - Combinationally from the S1 registers: and_r = a & b, or_r = a | b.
  - sum = a + (sub ? ~b : b) + sub, with sub = 1 for SUB/SLT; carry-out dropped.
  - ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the inverted-or-not b.
  - less = {WIDTH-1 zeros, sum[MSB] ^ ovf}, a correct signed compare.
  - sel = 00 AND, 01 OR, 10 ADD/SUB, 11 SLT.
- Stage 2 (v2): on S1→S2 transfer, register result = mux(sel) of {and_r, or_r, sum, less}, zero = (mux == 0), overflow = ovf for ADD/SUB else 0.
- Illegal codes: result = 0, zero = 1, overflow = 0, illegal = 1; the operation still flows through.
- Advance rules:
  - s2_free = !v2 || out_ready.
  - S1→S2 when v1 && s2_free.
  - in_ready = !v1 || s2_free.
- Stall: with out_valid = 1 and out_ready = 0, all S2 outputs hold stable. S1 holds its contents. in_ready = 0 only when both stages are full.
- Simultaneous accept and drain in the same cycle is allowed at every stage. Full throughput is one op per cycle.
- No internal overflow trap. Overflow is reported only; the consumer decides on any exception.

## Timing
- Latency: accept at edge N → out_valid = 1 after edge N+1 (2 edges from accept to result registered), assuming no stall.
- Throughput: 1 op/cycle with out_ready held high.
- in_ready is combinational from v1, v2, out_ready. All other outputs are registered.
- Reset (rst_n = 0 at a rising edge):
  - v1 = v2 = 0, so out_valid = 0.
  - result = 0, zero = 0, overflow = 0, illegal = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards both in-flight ops. No partial result is emitted.
- Data registers may be left un-reset internally, but result, zero, overflow and illegal must read 0 after reset.

## Test plan
- Each op, no stall, WIDTH = 32:
  - a = 0x0000_00F0, b = 0x0000_0F0F gives AND → 0x0000_0000 with zero = 1.
  - Same operands, OR → 0x0000_0FFF.
  - ADD 7 + 5 → 12.
  - SUB 5 − 7 → 0xFFFF_FFFE.
  - Each result appears 2 cycles after accept.
- Overflow and signed compare:
  - ADD 0x7FFF_FFFF + 1 → 0x8000_0000, overflow = 1.
  - SUB 0x8000_0000 − 1 → overflow = 1.
  - SLT 0x8000_0000 < 1 → 1 (overflow = 0 on SLT).
  - SLT 5 < −3 → 0.
- Back-to-back stream of 8 ADDs (i + i), out_ready = 1: expect out_valid high for 8 consecutive cycles, results 0, 2, …, 14 in order.
- Backpressure: stream 4 ops with out_ready = 0 for 5 cycles, then 1.
  - in_ready drops after 2 accepts.
  - result holds stable during the stall.
  - All 4 results emerge in order with no loss or duplication.
- Illegal alu_ctl = 1111 with a = 3, b = 4 → result 0, zero = 1, illegal = 1. A following legal ADD → illegal = 0.
- Reset mid-stream: assert rst_n = 0 while both stages are full → next cycle out_valid = 0, result = 0, in_ready = 1, and no stale result appears afterward.
